// File: rtl/pdm_feeder_pkg.sv
// Shared types and constants for the PDM sample feeder.
package pdm_feeder_pkg;

    typedef enum logic {IDLE, PLAY} feeder_state_t;

    typedef logic signed [7:0] sample_t;

    localparam logic [7:0] UNDERFLOW_MAX = 8'd255;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous single-clock FIFO for audio samples; occupancy is exported as fill.
module sample_fifo
    import pdm_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int FW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic          full,
    output logic          empty,
    output logic [FW-1:0] fill
);

    localparam int AW = $clog2(DEPTH);

    sample_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [FW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign full     = (count == FW'(DEPTH));
    assign empty    = (count == '0);
    assign fill     = count;
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // NOTE: storage has no reset; the pointers and count define validity.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: non-blocking assignments keep every register update in the same time step.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pdm_sample_feeder.sv
// Buffers streamed audio samples and releases one held level per sample period.
// Optional PDM_FEEDER_VOLUME_EN adds a volume_in arithmetic right-shift on playback.
module pdm_sample_feeder
    import pdm_feeder_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int PRIME         = 8,
    parameter int SAMPLE_PERIOD = 2268,
    parameter int PDM_PERIOD    = 4,
    localparam int FW           = $clog2(DEPTH + 1)
) (
    input  logic               clk_in,
    input  logic               rst_in,
`ifdef PDM_FEEDER_VOLUME_EN
    input  logic [2:0]         volume_in,
`endif
    input  logic signed [7:0]  sample_in,
    input  logic               sample_valid_in,
    output logic               sample_ready_out,
    output logic signed [7:0]  level_out,
    output logic               tick_out,
    output logic               data_ready_out,
    output logic               underflow_out,
    output logic [7:0]         underflow_count_out,
    output logic [FW-1:0]      fill_out
);

    localparam int SW = $clog2(SAMPLE_PERIOD);
    localparam int TW = (PDM_PERIOD > 1) ? $clog2(PDM_PERIOD) : 1;

    logic [SW-1:0]  sample_cnt;
    logic [TW-1:0]  tick_cnt;
    logic           strobe;

    feeder_state_t  state_q, state_d;
    sample_t        level_q, level_d;
    logic           data_ready_q, data_ready_d;
    logic           underflow_q, underflow_d;
    logic [7:0]     uf_count_q, uf_count_d;

    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FW-1:0]  fifo_fill;
    sample_t        fifo_head;
    sample_t        scaled_head;

    assign sample_ready_out = !fifo_full && !rst_in;
    assign fifo_push        = sample_valid_in && sample_ready_out;
    assign strobe           = (sample_cnt == SW'(SAMPLE_PERIOD - 1)) && !rst_in;

`ifdef PDM_FEEDER_VOLUME_EN
    assign scaled_head = fifo_head >>> volume_in;
`else
    assign scaled_head = fifo_head;
`endif

    sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (fifo_push),
        .push_data (sample_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .fill      (fifo_fill)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sample_cnt <= '0;
            tick_cnt   <= '0;
        end else begin
            sample_cnt <= (sample_cnt == SW'(SAMPLE_PERIOD - 1)) ? '0 : sample_cnt + 1'b1;
            tick_cnt   <= (tick_cnt == TW'(PDM_PERIOD - 1)) ? '0 : tick_cnt + 1'b1;
        end
    end

    // NOTE: every output of this block takes a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        data_ready_d = 1'b0;
        underflow_d  = 1'b0;
        uf_count_d   = uf_count_q;
        fifo_pop     = 1'b0;
        if (strobe) begin
            case (state_q)
                IDLE: begin
                    if (fifo_fill >= FW'(PRIME)) begin
                        fifo_pop     = 1'b1;
                        level_d      = scaled_head;
                        data_ready_d = 1'b1;
                        state_d      = PLAY;
                    end
                end
                PLAY: begin
                    if (!fifo_empty) begin
                        fifo_pop     = 1'b1;
                        level_d      = scaled_head;
                        data_ready_d = 1'b1;
                    end else begin
                        // A sample pushed this cycle is stored; the gap is still an underflow.
                        underflow_d = 1'b1;
                        level_d     = '0;
                        state_d     = IDLE;
                        if (uf_count_q != UNDERFLOW_MAX) begin
                            uf_count_d = uf_count_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            level_q      <= '0;
            data_ready_q <= 1'b0;
            underflow_q  <= 1'b0;
            uf_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            data_ready_q <= data_ready_d;
            underflow_q  <= underflow_d;
            uf_count_q   <= uf_count_d;
        end
    end

    assign level_out           = level_q;
    assign tick_out            = (tick_cnt == TW'(PDM_PERIOD - 1)) && !rst_in;
    assign data_ready_out      = data_ready_q;
    assign underflow_out       = underflow_q;
    assign underflow_count_out = uf_count_q;
    assign fill_out            = fifo_fill;

endmodule

// File: tb/tb_pdm_sample_feeder.sv
// Directed testbench for pdm_sample_feeder (SAMPLE_PERIOD=8, PDM_PERIOD=2, DEPTH=4, PRIME=2).
module tb_pdm_sample_feeder;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b1;
    logic signed [7:0]  sample_in = '0;
    logic               sample_valid_in = 1'b0;
    logic               sample_ready_out;
    logic signed [7:0]  level_out;
    logic               tick_out;
    logic               data_ready_out;
    logic               underflow_out;
    logic [7:0]         underflow_count_out;
    logic [2:0]         fill_out;
`ifdef PDM_FEEDER_VOLUME_EN
    logic [2:0]         volume_in = 3'd0;
`endif

    int checks = 0;
    int errors = 0;
    int phase  = 0;

    pdm_sample_feeder #(
        .DEPTH(4), .PRIME(2), .SAMPLE_PERIOD(8), .PDM_PERIOD(2)
    ) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
`ifdef PDM_FEEDER_VOLUME_EN
        .volume_in           (volume_in),
`endif
        .sample_in           (sample_in),
        .sample_valid_in     (sample_valid_in),
        .sample_ready_out    (sample_ready_out),
        .level_out           (level_out),
        .tick_out            (tick_out),
        .data_ready_out      (data_ready_out),
        .underflow_out       (underflow_out),
        .underflow_count_out (underflow_count_out),
        .fill_out            (fill_out)
    );

    always #5 clk_in = ~clk_in;

    // Expected position inside the 8-cycle sample period.
    always @(posedge clk_in) begin
        if (rst_in) phase <= 0;
        else        phase <= (phase == 7) ? 0 : phase + 1;
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_strobe();
        int n = 0;
        do begin
            step();
            n++;
        end while (phase != 0 && n < 16);
        if (phase != 0) begin
            errors++;
            $display("FAIL wait_strobe: no strobe within %0d cycles", n);
        end
    endtask

    task automatic push_one(input logic signed [7:0] v);
        sample_in       = v;
        sample_valid_in = 1'b1;
        step();
        sample_valid_in = 1'b0;
    endtask

    task automatic expect_strobe(input string name, input logic signed [7:0] lvl,
                                 input logic dr, input logic uf, input logic [2:0] fl);
        checks++;
        if (level_out !== lvl) begin
            errors++;
            $display("FAIL %s level: got %0d want %0d", name, level_out, lvl);
        end
        checks++;
        if (data_ready_out !== dr) begin
            errors++;
            $display("FAIL %s data_ready: got %b want %b", name, data_ready_out, dr);
        end
        checks++;
        if (underflow_out !== uf) begin
            errors++;
            $display("FAIL %s underflow: got %b want %b", name, underflow_out, uf);
        end
        checks++;
        if (fill_out !== fl) begin
            errors++;
            $display("FAIL %s fill: got %0d want %0d", name, fill_out, fl);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) step();
        checks++;
        if ({sample_ready_out, tick_out, data_ready_out, underflow_out} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {sample_ready_out, tick_out, data_ready_out, underflow_out});
        end
        checks++;
        if (level_out !== 8'sd0 || fill_out !== 3'd0 || underflow_count_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_values: level %0d fill %0d ucount %0d want 0 0 0",
                     level_out, fill_out, underflow_count_out);
        end
        rst_in = 1'b0;
        #1;
        checks++;
        if (sample_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", sample_ready_out);
        end
        for (int i = 1; i <= 16; i++) begin
            step();
            checks++;
            if (tick_out !== logic'(i % 2)) begin
                errors++;
                $display("FAIL reset_tick cycle %0d: got %b want %b", i, tick_out, i % 2);
            end
            checks++;
            if (data_ready_out !== 1'b0 || level_out !== 8'sd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: dr %b level %0d want 0 0",
                         i, data_ready_out, level_out);
            end
        end
    endtask

    task automatic test_playback();
        push_one(8'sd10);
        push_one(-8'sd20);
        push_one(8'sd30);
        push_one(-8'sd40);
        checks++;
        if (fill_out !== 3'd4) begin
            errors++;
            $display("FAIL play_fill: got %0d want 4", fill_out);
        end
        wait_strobe();
        expect_strobe("play_1", 8'sd10, 1'b1, 1'b0, 3'd3);
        step();
        expect_strobe("play_1_hold", 8'sd10, 1'b0, 1'b0, 3'd3);
        wait_strobe();
        expect_strobe("play_2", -8'sd20, 1'b1, 1'b0, 3'd2);
        wait_strobe();
        expect_strobe("play_3", 8'sd30, 1'b1, 1'b0, 3'd1);
        wait_strobe();
        expect_strobe("play_4", -8'sd40, 1'b1, 1'b0, 3'd0);
    endtask

    task automatic test_underflow();
        wait_strobe();
        expect_strobe("uf_strobe", 8'sd0, 1'b0, 1'b1, 3'd0);
        checks++;
        if (underflow_count_out !== 8'd1) begin
            errors++;
            $display("FAIL uf_count: got %0d want 1", underflow_count_out);
        end
        step();
        expect_strobe("uf_pulse_end", 8'sd0, 1'b0, 1'b0, 3'd0);
        push_one(8'sd5);
        wait_strobe();
        expect_strobe("uf_no_resume", 8'sd0, 1'b0, 1'b0, 3'd1);
        push_one(8'sd6);
        wait_strobe();
        expect_strobe("uf_resume", 8'sd5, 1'b1, 1'b0, 3'd1);
    endtask

    task automatic test_full();
        push_one(8'sd7);
        push_one(8'sd8);
        push_one(8'sd9);
        sample_in       = 8'sd11;
        sample_valid_in = 1'b1;
        for (int n = 0; n < 8 && phase != 7; n++) begin
            checks++;
            if (sample_ready_out !== 1'b0 || fill_out !== 3'd4) begin
                errors++;
                $display("FAIL full_hold: ready %b fill %0d want 0 4", sample_ready_out, fill_out);
            end
            step();
        end
        checks++;
        if (sample_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL full_strobe_ready: got %b want 0", sample_ready_out);
        end
        step();
        sample_valid_in = 1'b0;
        expect_strobe("full_pop", 8'sd6, 1'b1, 1'b0, 3'd3);
    endtask

    task automatic test_reset_mid();
        rst_in = 1'b1;
        step();
        expect_strobe("midrst", 8'sd0, 1'b0, 1'b0, 3'd0);
        checks++;
        if (underflow_count_out !== 8'd0 || tick_out !== 1'b0) begin
            errors++;
            $display("FAIL midrst_misc: ucount %0d tick %b want 0 0", underflow_count_out, tick_out);
        end
        rst_in = 1'b0;
        push_one(8'sd3);
        wait_strobe();
        expect_strobe("midrst_idle", 8'sd0, 1'b0, 1'b0, 3'd1);
    endtask

    task automatic test_saturation();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        for (int i = 0; i < 256; i++) begin
            push_one(8'sd1);
            push_one(8'sd2);
            wait_strobe();
            wait_strobe();
            wait_strobe();
            checks++;
            if (underflow_count_out !== 8'((i + 1 > 255) ? 255 : i + 1)) begin
                errors++;
                $display("FAIL sat_count iter %0d: got %0d want %0d",
                         i, underflow_count_out, (i + 1 > 255) ? 255 : i + 1);
            end
        end
    endtask

`ifdef PDM_FEEDER_VOLUME_EN
    task automatic test_volume();
        rst_in = 1'b1;
        step();
        rst_in    = 1'b0;
        volume_in = 3'd1;
        push_one(-8'sd128);
        push_one(8'sd127);
        wait_strobe();
        expect_strobe("vol_neg", -8'sd64, 1'b1, 1'b0, 3'd1);
        wait_strobe();
        expect_strobe("vol_pos", 8'sd63, 1'b1, 1'b0, 3'd0);
    endtask
`endif

    initial begin
        test_reset();
        test_playback();
        test_underflow();
        test_full();
        test_reset_mid();
        test_saturation();
`ifdef PDM_FEEDER_VOLUME_EN
        test_volume();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
